// File: rtl/fp32_divider.sv
// Sequential IEEE-754 single-precision divider, restoring, one quotient bit per cycle.
// Latency: done pulses 1 cycle after the start edge for special operands, 27 for normal ones.
// No backpressure: start is taken only in IDLE/DONE and ignored while busy.
module fp32_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  round_mode,
  output logic        busy,
  output logic        done,
  output logic [31:0] resultDiv,
  output logic        errorDiv,
  output logic        overflowDiv,
  output logic        divByZero
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_DIVIDE = 3'd2,
    S_ROUND  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  // Latched operation
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [1:0]        r_mode;

  // Iteration state
  logic signed [9:0] r_exp;
  logic [23:0]       r_div;
  logic [25:0]       r_rem;
  logic [24:0]       r_quo;
  logic [4:0]        r_cnt;

  // Held outputs
  logic [31:0]       r_result;
  logic              r_err;
  logic              r_ovf;
  logic              r_dbz;

  // Operand decode (exponent 0 means zero, denormals are flushed)
  logic              w_sign;
  logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic              w_special;
  logic              w_accept;
  logic [23:0]       w_m1, w_m2;
  logic              w_lt;
  logic signed [9:0] w_exp_raw, w_exp_adj;
  logic [25:0]       w_rem_init;

  // Special-case result
  logic [31:0]       w_sp_result;
  logic              w_sp_err;
  logic              w_sp_dbz;

  // Divide step
  logic              w_trial_ok;
  logic [25:0]       w_rem_next;

  // Rounding
  logic              w_guard, w_sticky, w_inexact, w_inc;
  logic [24:0]       w_mant_inc;
  logic              w_carry;
  logic [23:0]       w_mant_fin;
  logic signed [9:0] w_exp_fin;
  logic              w_rnd_ovf, w_rnd_unf;
  logic [31:0]       w_rnd_result;

  assign w_sign    = r_a[31] ^ r_b[31];
  assign w_a_nan   = (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'd0);
  assign w_b_nan   = (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'd0);
  assign w_a_inf   = (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'd0);
  assign w_b_inf   = (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'd0);
  assign w_a_zero  = (r_a[30:23] == 8'h00);
  assign w_b_zero  = (r_b[30:23] == 8'h00);
  assign w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;

  assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Normalise so the quotient lands in [1,2): pre-shift the dividend when it is the smaller mantissa
  assign w_m1       = {1'b1, r_a[22:0]};
  assign w_m2       = {1'b1, r_b[22:0]};
  assign w_lt       = (w_m1 < w_m2);
  assign w_exp_raw  = $signed({2'b00, r_a[30:23]}) - $signed({2'b00, r_b[30:23]}) + 10'sd127;
  assign w_exp_adj  = w_lt ? (w_exp_raw - 10'sd1) : w_exp_raw;
  assign w_rem_init = w_lt ? {1'b0, w_m1, 1'b0} : {2'b00, w_m1};

  // Special-operand result; NaN-producing cases take priority over infinities and zeros
  always_comb begin
    w_sp_result = 32'h7FC0_0000;
    w_sp_err    = 1'b1;
    w_sp_dbz    = 1'b0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf) || (w_a_zero && w_b_zero)) begin
      w_sp_result = 32'h7FC0_0000;
    end else if (w_a_inf) begin
      w_sp_result = {w_sign, 8'hFF, 23'd0};
      w_sp_err    = 1'b0;
    end else if (w_b_inf || w_a_zero) begin
      w_sp_result = {w_sign, 31'd0};
      w_sp_err    = 1'b0;
    end else begin
      w_sp_result = {w_sign, 8'hFF, 23'd0};
      w_sp_dbz    = 1'b1;
    end
  end

  // Restoring step: keep the difference only when the subtraction does not borrow
  assign w_trial_ok = (r_rem >= {2'b00, r_div});
  assign w_rem_next = (w_trial_ok ? (r_rem - {2'b00, r_div}) : r_rem) << 1;

  // Rounding: r_quo[24:1] is the 24-bit mantissa, r_quo[0] the guard bit
  assign w_guard   = r_quo[0];
  assign w_sticky  = |r_rem;
  assign w_inexact = w_guard | w_sticky;

  // Round-increment decision per rounding mode
  always_comb begin
    w_inc = 1'b0;
    case (r_mode)
      2'b10:   w_inc = w_guard & (w_sticky | r_quo[1]);
      2'b11:   w_inc = 1'b0;
      2'b00:   w_inc = ~w_sign & w_inexact;
      2'b01:   w_inc = w_sign & w_inexact;
      default: w_inc = 1'b0;
    endcase
  end

  assign w_mant_inc = {1'b0, r_quo[24:1]} + {24'd0, w_inc};
  assign w_carry    = w_mant_inc[24];
  assign w_mant_fin = w_carry ? w_mant_inc[24:1] : w_mant_inc[23:0];
  assign w_exp_fin  = r_exp + $signed({9'd0, w_carry});
  assign w_rnd_ovf  = (w_exp_fin >= 10'sd255);
  assign w_rnd_unf  = (w_exp_fin <= 10'sd0);

  // Final packing after rounding: saturate to infinity or flush to zero at the range limits
  always_comb begin
    w_rnd_result = {w_sign, w_exp_fin[7:0], w_mant_fin[22:0]};
    if (w_rnd_ovf) begin
      w_rnd_result = {w_sign, 8'hFF, 23'd0};
    end else if (w_rnd_unf) begin
      w_rnd_result = {w_sign, 31'd0};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; specials skip the iteration and go straight to DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_SETUP;
      S_SETUP:  w_next = w_special ? S_DONE : S_DIVIDE;
      S_DIVIDE: if (r_cnt == 5'd1) w_next = S_ROUND;
      S_ROUND:  w_next = S_DONE;
      S_DONE:   w_next = start ? S_SETUP : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result/flag update on entry to DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_mode   <= 2'd0;
      r_exp    <= 10'sd0;
      r_div    <= 24'd0;
      r_rem    <= 26'd0;
      r_quo    <= 25'd0;
      r_cnt    <= 5'd0;
      r_result <= 32'd0;
      r_err    <= 1'b0;
      r_ovf    <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a    <= A;
        r_b    <= B;
        r_mode <= round_mode;
      end
      case (r_state)
        S_SETUP: begin
          if (w_special) begin
            r_result <= w_sp_result;
            r_err    <= w_sp_err;
            r_ovf    <= 1'b0;
            r_dbz    <= w_sp_dbz;
          end else begin
            r_exp <= w_exp_adj;
            r_div <= w_m2;
            r_rem <= w_rem_init;
            r_quo <= 25'd0;
            r_cnt <= 5'd25;
          end
        end
        S_DIVIDE: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[23:0], w_trial_ok};
          r_cnt <= r_cnt - 5'd1;
        end
        S_ROUND: begin
          r_result <= w_rnd_result;
          r_err    <= w_rnd_ovf;
          r_ovf    <= w_rnd_ovf;
          r_dbz    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state == S_SETUP) || (r_state == S_DIVIDE) || (r_state == S_ROUND);
  assign done        = (r_state == S_DONE);
  assign resultDiv   = r_result;
  assign errorDiv    = r_err;
  assign overflowDiv = r_ovf;
  assign divByZero   = r_dbz;

endmodule

// File: tb/tb_fp32_divider.sv
// Testbench for fp32_divider: directed cases, handshake/reset cases, and random operands.
// Expected results come from a value-level division model using integer arithmetic.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fp32_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [1:0]  round_mode = 2'd0;
  logic        busy, done;
  logic [31:0] resultDiv;
  logic        errorDiv, overflowDiv, divByZero;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp32_divider dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .A          (A),
    .B          (B),
    .round_mode (round_mode),
    .busy       (busy),
    .done       (done),
    .resultDiv  (resultDiv),
    .errorDiv   (errorDiv),
    .overflowDiv(overflowDiv),
    .divByZero  (divByZero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags_now();
    return {29'd0, errorDiv, overflowDiv, divByZero};
  endfunction

  // Reference: classify operands, then divide the scaled mantissas as integers
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                       output logic [31:0] res, output logic [2:0] fl, output int lat);
    logic   s, anan, bnan, ainf, binf, azero, bzero, g, st, up;
    int     ea, eb, e;
    longint ma, mb, num, q, mant;
    s     = a[31] ^ b[31];
    ea    = int'(a[30:23]);
    eb    = int'(b[30:23]);
    anan  = (ea == 255) && (a[22:0] != 0);
    bnan  = (eb == 255) && (b[22:0] != 0);
    ainf  = (ea == 255) && (a[22:0] == 0);
    binf  = (eb == 255) && (b[22:0] == 0);
    azero = (ea == 0);
    bzero = (eb == 0);
    lat   = 1;
    fl    = 3'b000;
    res   = 32'd0;
    if (anan || bnan || (ainf && binf) || (azero && bzero)) begin
      res = 32'h7FC00000; fl = 3'b100;
    end else if (ainf) begin
      res = {s, 8'hFF, 23'd0};
    end else if (binf || azero) begin
      res = {s, 31'd0};
    end else if (bzero) begin
      res = {s, 8'hFF, 23'd0}; fl = 3'b101;
    end else begin
      lat = 27;
      ma  = longint'(a[22:0]) + (longint'(1) << 23);
      mb  = longint'(b[22:0]) + (longint'(1) << 23);
      e   = ea - eb + 127;
      if (ma < mb) begin
        num = ma << 25;
        e   = e - 1;
      end else begin
        num = ma << 24;
      end
      q    = num / mb;
      st   = (num % mb) != 0;
      mant = q >> 1;
      g    = q[0];
      case (rm)
        2'b10:   up = g && (st || mant[0]);
        2'b00:   up = !s && (g || st);
        2'b01:   up = s && (g || st);
        default: up = 1'b0;
      endcase
      if (up) mant = mant + 1;
      if (mant == (longint'(1) << 24)) begin
        mant = mant >> 1;
        e    = e + 1;
      end
      if (e >= 255) begin
        res = {s, 8'hFF, 23'd0}; fl = 3'b110;
      end else if (e <= 0) begin
        res = {s, 31'd0};
      end else begin
        res = {s, 8'(e), 23'(mant)};
      end
    end
  endtask

  function automatic logic [31:0] rnd_op();
    logic [7:0]  e;
    logic [22:0] f;
    int          c;
    c = $urandom_range(0, 9);
    if (c == 0)      e = 8'h00;
    else if (c == 1) e = 8'hFF;
    else if (c <= 3) e = 8'($urandom_range(1, 254));
    else             e = 8'($urandom_range(100, 154));
    f = ($urandom_range(0, 7) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  // One-cycle start pulse; returns just after the accepting edge
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
    @(negedge clk);
    A = a; B = b; round_mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges until done, bounded so a stuck DUT still reaches the summary
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (done !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] m, input logic [31:0] er, input logic [2:0] ef,
                           input int el);
    int n;
    launch(a, b, m);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    wait_done(0, n);
    chk({tag, " latency"}, 32'(n), 32'(el));
    chk({tag, " result"}, resultDiv, er);
    chk({tag, " flags"}, flags_now(), {29'd0, ef});
    @(negedge clk);
    chk({tag, " done pulse"}, 32'(done), 32'd0);
  endtask

  logic [31:0] d_a  [11];
  logic [31:0] d_b  [11];
  logic [1:0]  d_m  [11];
  logic [31:0] d_r  [11];
  logic [2:0]  d_f  [11];
  int          d_l  [11];

  initial begin
    int          n;
    int          seen;
    logic [31:0] er;
    logic [2:0]  ef;
    int          el;
    logic [31:0] ra, rb;
    logic [1:0]  rm;

    d_a = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hBF800000, 32'hBF800000,
            32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7F000000, 32'h00800000};
    d_b = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h40400000, 32'h40400000, 32'h40400000,
            32'h00000000, 32'h00000000, 32'hC0000000, 32'h3E800000, 32'h4F000000};
    d_m = '{2'b10, 2'b10, 2'b11, 2'b00, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    d_r = '{32'h40400000, 32'h3EAAAAAB, 32'h3EAAAAAA, 32'h3EAAAAAB, 32'hBEAAAAAB, 32'hBEAAAAAA,
            32'h7F800000, 32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'h00000000};
    d_f = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
            3'b101, 3'b100, 3'b000, 3'b110, 3'b000};
    d_l = '{27, 27, 27, 27, 27, 27, 1, 1, 1, 27, 27};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", resultDiv, 32'd0);
    chk("reset flags", flags_now(), 32'd0);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      run_check($sformatf("dir%0d", i), d_a[i], d_b[i], d_m[i], d_r[i], d_f[i], d_l[i]);
    end

    // start during DIVIDE is ignored, outputs hold the previous result meanwhile
    run_check("pre", 32'h3F800000, 32'h40400000, 2'b10, 32'h3EAAAAAB, 3'b000, 27);
    launch(32'h40C00000, 32'h40000000, 2'b10);
    repeat (5) @(negedge clk);
    chk("hold result", resultDiv, 32'h3EAAAAAB);
    A = 32'h3F800000; B = 32'h00000000; round_mode = 2'b11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, n);
    chk("ignore latency", 32'(n), 32'd27);
    chk("ignore result", resultDiv, 32'h40400000);
    chk("ignore flags", flags_now(), 32'd0);

    // start held in the DONE cycle launches the next operation back-to-back
    A = 32'hBF800000; B = 32'h40400000; round_mode = 2'b01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b busy", 32'(busy), 32'd1);
    wait_done(0, n);
    chk("b2b latency", 32'(n), 32'd27);
    chk("b2b result", resultDiv, 32'hBEAAAAAB);

    // Random operands against the model
    for (int i = 0; i < 150; i++) begin
      ra = rnd_op();
      rb = rnd_op();
      rm = 2'($urandom_range(0, 3));
      model(ra, rb, rm, er, ef, el);
      run_check($sformatf("rnd%0d %h/%h m%0d", i, ra, rb, rm), ra, rb, rm, er, ef, el);
    end

    // Reset mid-operation aborts with no done pulse
    run_check("pre-rst", 32'h3F800000, 32'h40400000, 2'b11, 32'h3EAAAAAA, 3'b000, 27);
    launch(32'h40C00000, 32'h40000000, 2'b10);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort result", resultDiv, 32'd0);
    chk("abort flags", flags_now(), 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    chk("abort no done", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
